// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared constants and types for the pipelined instruction memory.
// Holds default geometry, the response record, the FSM state encoding and the
// MIPS opcode values used when building program images.
package inst_mem_pkg;

  localparam int INST_DATA_W = 32;
  localparam int INST_DEPTH  = 256;

  // Width of the byte offset inside one default-sized instruction word.
  localparam int BYTE_OFS_W  = $clog2(INST_DATA_W / 8);

  // Response record as seen by the IF/ID register.
  typedef struct packed {
    logic [INST_DATA_W-1:0] data;
    logic                   err;
  } rsp_t;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Primary opcode field values (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/inst_mem_ram.sv
// inst_mem_ram: 1R1W synchronous-read word array with read-before-write.
// The read register can be synchronously cleared so the response path shows 0
// after reset and on rejected addresses. Optional macro INST_MEM_PIPE_PARITY_EN
// adds a per-word even-parity bit and a registered mismatch flag.
module inst_mem_ram
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = INST_DATA_W,
  parameter int DEPTH  = INST_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_perr_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

`ifdef INST_MEM_PIPE_PARITY_EN
  logic par_q [DEPTH];
  logic rd_perr_q;

  function automatic logic calc_par(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Store the even-parity bit alongside every loaded word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      par_q[wr_idx_i] <= calc_par(wr_data_i);
    end
  end

  // Register the parity check with the read so it lines up with the data.
  always_ff @(posedge clk) begin
    if (rd_clr_i) begin
      rd_perr_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_perr_q <= calc_par(mem_q[rd_idx_i]) ^ par_q[rd_idx_i];
    end
  end

  assign rd_perr_o = rd_perr_q;
`else
  assign rd_perr_o = 1'b0;
`endif

  // Word array write; non-blocking update makes a same-edge read see the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read register: clear has priority, otherwise capture on a read strobe.
  always_ff @(posedge clk) begin
    if (rd_clr_i) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: synchronous-read instruction memory for the IF stage.
// Valid/ready fetch port with byte addressing, alignment and range checks,
// a single-entry response register, branch-redirect flush, a runtime load port
// and a consumed-fetch counter. Optional macro INST_MEM_PIPE_PARITY_EN adds
// stored parity and the par_err output.
module inst_mem_pipe
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = INST_DATA_W,
  parameter int DEPTH  = INST_DEPTH,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
`ifdef INST_MEM_PIPE_PARITY_EN
  output logic              par_err,
`endif
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam int OFS_W = $clog2(DATA_W / 8);
  localparam int HI_W  = ADDR_W - OFS_W - IDX_W;

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept_s;
  logic              consume_s;
  logic              misal_s;
  logic              oor_s;
  logic              addr_err_s;
  logic [IDX_W-1:0]  idx_s;
  logic              rd_clr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              rd_perr_s;

  assign idx_s   = req_addr[OFS_W+IDX_W-1:OFS_W];
  assign misal_s = |req_addr[OFS_W-1:0];

  generate
    if (HI_W > 0) begin : g_oor
      assign oor_s = |req_addr[ADDR_W-1:OFS_W+IDX_W];
    end else begin : g_no_oor
      assign oor_s = 1'b0;
    end
  endgenerate

  assign addr_err_s = misal_s | oor_s;

  // A new request can enter whenever the output slot is free or being vacated.
  assign req_ready = (state_q == ST_EMPTY) || rsp_ready || flush;
  assign accept_s  = req_valid && req_ready;
  // A flushed response is discarded, so it is never counted.
  assign consume_s = (state_q == ST_HOLD) && rsp_ready && !flush;

  // Rejected addresses read as zero; reset also clears the read register.
  assign rd_clr_s = reset || (accept_s && addr_err_s);

  inst_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ld_en),
    .wr_idx_i  (ld_idx),
    .wr_data_i (ld_data),
    .rd_en_i   (accept_s),
    .rd_clr_i  (rd_clr_s),
    .rd_idx_i  (idx_s),
    .rd_data_o (rd_data_s),
    .rd_perr_o (rd_perr_s)
  );

  // Next-state logic for the output slot, error flag and counter.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_d = ST_HOLD;
        end else if (rsp_ready || flush) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (accept_s) begin
      err_d = addr_err_s;
    end else begin
      err_d = err_q;
    end
    if (consume_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      err_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == ST_HOLD);
  assign rsp_data  = rd_data_s;
  assign rsp_err   = err_q;
  assign fetch_cnt = cnt_q;

`ifdef INST_MEM_PIPE_PARITY_EN
  // The parity flag is only meaningful while a response is held.
  assign par_err = rd_perr_s && (state_q == ST_HOLD) && !err_q;
`else
  logic unused_perr_s;
  assign unused_perr_s = rd_perr_s;
`endif

endmodule

// File: tb/tb_inst_mem_pipe.sv
// tb_inst_mem_pipe: directed self-checking bench for inst_mem_pipe.
// Honours INST_MEM_PIPE_PARITY_EN to exercise the optional parity flag.
module tb_inst_mem_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 8;
  localparam int CNT_W  = 32;

  localparam logic [31:0] W0 = 32'h2010000F;
  localparam logic [31:0] W1 = 32'h20110019;
  localparam logic [31:0] W2 = 32'h20120014;
  localparam logic [31:0] W3 = 32'hAC090004;
  localparam logic [31:0] W4 = 32'h8C080000;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              flush;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  fetch_cnt;
`ifdef INST_MEM_PIPE_PARITY_EN
  logic              par_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_mem_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
`ifdef INST_MEM_PIPE_PARITY_EN
    .par_err   (par_err),
`endif
    .fetch_cnt (fetch_cnt)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_idx = 8'h0; ld_data = 32'h0;
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", rsp_err); end
    total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [31:0] w);
    ld_en = 1'b1; ld_idx = idx; ld_data = w;
    step();
    ld_en = 1'b0;
  endtask

  task automatic test_load_fetch();
    logic [31:0] exp_w [3];
    exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
    load_word(8'd0, W0); load_word(8'd1, W1); load_word(8'd2, W2);
    load_word(8'd3, W3); load_word(8'd4, W4);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_data !== exp_w[i] || rsp_err !== 1'b0) begin
        bad++; $display("FAIL fetch%0d got v=%0b d=%h e=%0b exp v=1 d=%h e=0", i, rsp_valid, rsp_data, rsp_err, exp_w[i]);
      end
    end
    req_valid = 1'b0;
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_drain got=%0b exp=0", rsp_valid); end
    total++; if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL fetch_cnt got=%0d exp=3", fetch_cnt); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", req_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_data !== W0) begin
        bad++; $display("FAIL bp_hold%0d got v=%0b d=%h exp v=1 d=%h", i, rsp_valid, rsp_data, W0);
      end
    end
    rsp_ready = 1'b1;
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_data !== W1) begin
      bad++; $display("FAIL bp_next got v=%0b d=%h exp v=1 d=%h", rsp_valid, rsp_data, W1);
    end
    req_valid = 1'b0;
    step();
    total++; if (fetch_cnt !== 32'd5) begin bad++; $display("FAIL bp_cnt got=%0d exp=5", fetch_cnt); end
  endtask

  task automatic test_errors();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h2;
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      bad++; $display("FAIL err_misal got v=%0b e=%0b d=%h exp v=1 e=1 d=0", rsp_valid, rsp_err, rsp_data);
    end
    req_addr = 32'(DEPTH * 4);
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      bad++; $display("FAIL err_range got v=%0b e=%0b d=%h exp v=1 e=1 d=0", rsp_valid, rsp_err, rsp_data);
    end
    req_valid = 1'b0;
    step();
    total++; if (fetch_cnt !== 32'd7) begin bad++; $display("FAIL err_cnt got=%0d exp=7", fetch_cnt); end
  endtask

  task automatic test_flush();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    step();
    flush = 1'b1; req_addr = 32'h10;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== W4 || fetch_cnt !== 32'd7) begin
      bad++; $display("FAIL flush_target got v=%0b d=%h c=%0d exp v=1 d=%h c=7", rsp_valid, rsp_data, fetch_cnt, W4);
    end
    rsp_ready = 1'b1;
    step();
    total++; if (fetch_cnt !== 32'd8) begin bad++; $display("FAIL flush_cnt got=%0d exp=8", fetch_cnt); end
  endtask

  task automatic test_rbw();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    ld_en = 1'b1; ld_idx = 8'd3; ld_data = 32'hDEADBEEF;
    step();
    ld_en = 1'b0;
    total++; if (rsp_data !== W3) begin bad++; $display("FAIL rbw_old got=%h exp=%h", rsp_data, W3); end
    step();
    req_valid = 1'b0;
    total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rbw_new got=%h exp=deadbeef", rsp_data); end
    step();
    total++; if (fetch_cnt !== 32'd10) begin bad++; $display("FAIL rbw_cnt got=%0d exp=10", fetch_cnt); end
  endtask

  task automatic test_reset_hold();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    step();
    reset = 1'b1; req_valid = 1'b0;
    step();
    reset = 1'b0;
    total++; if (rsp_valid !== 1'b0 || fetch_cnt !== 32'd0 || rsp_data !== 32'h0) begin
      bad++; $display("FAIL rst_hold got v=%0b c=%0d d=%h exp v=0 c=0 d=0", rsp_valid, fetch_cnt, rsp_data);
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== W1) begin
      bad++; $display("FAIL rst_retain got v=%0b d=%h exp v=1 d=%h", rsp_valid, rsp_data, W1);
    end
    step();
  endtask

`ifdef INST_MEM_PIPE_PARITY_EN
  task automatic test_parity();
    u_dut.u_ram.par_q[1] = ~u_dut.u_ram.par_q[1];
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    step();
    total++; if (par_err !== 1'b1) begin bad++; $display("FAIL par_bad got=%0b exp=1", par_err); end
    req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    total++; if (par_err !== 1'b0) begin bad++; $display("FAIL par_good got=%0b exp=0", par_err); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_errors();
    test_flush();
    test_rbw();
    test_reset_hold();
`ifdef INST_MEM_PIPE_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
